// File: rtl/npu_mem_reader_if.sv
// Output beat stream from the NPU memory reader to the compute engine.
// The master side presents a beat and the slave side accepts it with out_ready.
interface npu_mem_reader_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/npu_mem_reader.sv
// Streams image/conv/dense RAM contents to the NPU datapath.
// RAM read latency is absorbed by a valid pipe, and a credit-checked output FIFO provides backpressure.
//   state | meaning
//   IDLE  | waiting for start, no RAM reads
//   RUN   | issuing one read per cycle while credits allow
//   DRAIN | all reads issued, waiting for pipe and FIFO to empty
module npu_mem_reader #(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        src_sel,
    input  logic [15:0]       base_addr,
    input  logic [15:0]       length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [13:0]       img_addr,
    input  logic [7:0]        img_q0,
    input  logic [7:0]        img_q1,
    input  logic [7:0]        img_q2,
    input  logic [7:0]        img_q3,
    output logic [15:0]       conv_addr,
    input  logic [7:0]        conv_q,
    output logic [15:0]       dense_addr,
    input  logic [7:0]        dense_q,
    npu_mem_reader_if.master  strm
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [1:0]    sel_q;
    logic [15:0]   base_q, len_q, issued, beats_out;
    logic [RD_LAT:0] rd_pipe;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [31:0]   cap_data;
    logic [15:0]   rd_addr;
    logic accept, reject, issue, finish, credit_ok, push, pop;

    assign rd_addr   = base_q + issued;
    assign credit_ok = ($countones(rd_pipe) + int'(fifo_cnt)) < FIFO_DEPTH;
    assign push      = rd_pipe[RD_LAT];
    assign pop       = strm.out_valid && strm.out_ready;

    assign busy           = (state != IDLE);
    assign strm.out_valid = (fifo_cnt != '0);
    assign strm.out_data  = mem[rd_ptr];
    assign strm.out_last  = strm.out_valid && (beats_out == len_q - 16'd1);

    always_comb begin
        case (sel_q)
            2'b00:   cap_data = {img_q0, img_q1, img_q2, img_q3};
            2'b01:   cap_data = {conv_q, 24'h0};
            2'b10:   cap_data = {dense_q, 24'h0};
            default: cap_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        issue    = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (src_sel == 2'b11 || length == 16'd0) begin
                        reject = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (issued == len_q) state_nx = DRAIN;
                else if (credit_ok)  issue = 1'b1;
            end
            DRAIN: begin
                if (rd_pipe == '0 && fifo_cnt == '0) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done       <= 1'b0;
            err        <= 1'b0;
            sel_q      <= 2'b00;
            base_q     <= 16'h0;
            len_q      <= 16'h0;
            issued     <= 16'h0;
            beats_out  <= 16'h0;
            img_addr   <= 14'h0;
            conv_addr  <= 16'h0;
            dense_addr <= 16'h0;
            rd_pipe    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
        end else begin
            done    <= finish || reject;
            err     <= reject && (src_sel == 2'b11);
            rd_pipe <= {rd_pipe[RD_LAT-1:0], issue};
            if (accept) begin
                sel_q     <= src_sel;
                base_q    <= base_addr;
                len_q     <= length;
                issued    <= 16'h0;
                beats_out <= 16'h0;
            end
            // Only the selected RAM address moves; the others keep their last value.
            if (issue) begin
                issued <= issued + 16'd1;
                case (sel_q)
                    2'b00:   img_addr   <= rd_addr[13:0];
                    2'b01:   conv_addr  <= rd_addr;
                    2'b10:   dense_addr <= rd_addr;
                    default: ;
                endcase
            end
            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr    <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                beats_out <= beats_out + 16'd1;
            end
            if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
            else if (!push && pop) fifo_cnt <= fifo_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cap_data;
    end
endmodule

// File: tb/tb_npu_mem_reader.sv
// Directed and randomized bench for npu_mem_reader, with behavioural RAM contents and an
// expected-beat model derived from base/length/source.
module tb_npu_mem_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  src_sel;
    logic [15:0] base_addr, length;
    logic        busy, done, err;
    logic [13:0] img_addr;
    logic [7:0]  img_q0, img_q1, img_q2, img_q3, conv_q, dense_q;
    logic [15:0] conv_addr, dense_addr;

    npu_mem_reader_if strm();

    npu_mem_reader #(.RD_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .src_sel(src_sel),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done), .err(err),
        .img_addr(img_addr), .img_q0(img_q0), .img_q1(img_q1), .img_q2(img_q2), .img_q3(img_q3),
        .conv_addr(conv_addr), .conv_q(conv_q), .dense_addr(dense_addr), .dense_q(dense_q),
        .strm(strm)
    );

    always #5 clk = ~clk;

    logic [7:0] img_mem0 [16384];
    logic [7:0] img_mem1 [16384];
    logic [7:0] img_mem2 [16384];
    logic [7:0] img_mem3 [16384];
    logic [7:0] conv_mem [65536];
    logic [7:0] dense_mem [65536];

    // Synchronous RAMs with one cycle of read latency.
    always @(posedge clk) begin
        img_q0  <= img_mem0[img_addr];
        img_q1  <= img_mem1[img_addr];
        img_q2  <= img_mem2[img_addr];
        img_q3  <= img_mem3[img_addr];
        conv_q  <= conv_mem[conv_addr];
        dense_q <= dense_mem[dense_addr];
    end

    int errors = 0;
    int checks = 0;
    logic [13:0] m_img;
    logic [15:0] m_conv, m_dense;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_beat(input logic [1:0] sel, input logic [15:0] a);
        logic [13:0] ia;
        ia = a[13:0];
        case (sel)
            2'b00:   return {img_mem0[ia], img_mem1[ia], img_mem2[ia], img_mem3[ia]};
            2'b01:   return {conv_mem[a], 24'h0};
            default: return {dense_mem[a], 24'h0};
        endcase
    endfunction

    task automatic check_addrs(input string tag);
        check({tag, "_img_addr"}, 32'(img_addr), 32'(m_img));
        check({tag, "_conv_addr"}, 32'(conv_addr), 32'(m_conv));
        check({tag, "_dense_addr"}, 32'(dense_addr), 32'(m_dense));
    endtask

    // Immediate commands: zero length or reserved source.
    task automatic run_imm(input logic [1:0] sel, input logic [15:0] base, input logic [15:0] len);
        @(negedge clk);
        start = 1'b1; src_sel = sel; base_addr = base; length = len;
        @(negedge clk);
        start = 1'b0;
        check("imm_done", 32'(done), 32'd1);
        check("imm_err", 32'(err), (sel == 2'b11) ? 32'd1 : 32'd0);
        check("imm_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("imm_done_pulse", 32'(done), 32'd0);
        check("imm_no_valid", 32'(strm.out_valid), 32'd0);
        check_addrs("imm");
    endtask

    task automatic run_cmd(input logic [1:0] sel, input logic [15:0] base, input logic [15:0] len,
                           input int rmode, input int inject_cyc, input int abort_beat,
                           input bit check_lat);
        int idx, dones, first_v, last_hs, stop, budget;
        bit fin;
        logic [15:0] a;
        idx = 0; dones = 0; first_v = -1; last_hs = -1; stop = 0; fin = 0;
        budget = int'(len) * 4 + 60;
        @(negedge clk);
        start = 1'b1; src_sel = sel; base_addr = base; length = len;
        @(negedge clk);
        start = 1'b0;
        check("cmd_busy", 32'(busy), 32'd1);
        for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (cyc == inject_cyc) begin
                start = 1'b1; src_sel = 2'b00; base_addr = 16'h1234; length = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (abort_beat >= 0 && idx == abort_beat) begin
                reset = 1'b1; strm.out_ready = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                check("abort_valid", 32'(strm.out_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("abort_no_done", 32'(done), 32'd0);
                end
                m_img = 14'h0; m_conv = 16'h0; m_dense = 16'h0;
                check_addrs("abort");
                return;
            end
            case (rmode)
                0:       strm.out_ready = 1'b1;
                1:       strm.out_ready = (cyc % 3 == 0);
                default: strm.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (idx >= int'(len)) begin
                check("no_extra_valid", 32'(strm.out_valid), 32'd0);
            end else if (strm.out_valid) begin
                if (first_v < 0) first_v = cyc;
                a = base + 16'(idx);
                check("beat_data", strm.out_data, exp_beat(sel, a));
                check("beat_last", 32'(strm.out_last), (idx == int'(len) - 1) ? 32'd1 : 32'd0);
                if (strm.out_ready) begin
                    idx++;
                    last_hs = cyc;
                end
            end
            if (done) begin
                dones++;
                check("done_err", 32'(err), 32'd0);
                check("done_after_all_beats", 32'(idx), 32'(len));
                check("busy_low_at_done", 32'(busy), 32'd0);
                if (stop == 0) stop = cyc + 4;
            end
            if (stop > 0 && cyc >= stop) fin = 1;
        end
        strm.out_ready = 1'b0;
        check("cmd_completed_in_budget", 32'(fin), 32'd1);
        check("done_count", 32'(dones), 32'd1);
        check("beat_count", 32'(idx), 32'(len));
        if (check_lat) begin
            check("first_valid_cycle", 32'(first_v), 32'd4);
            check("last_beat_cycle", 32'(last_hs), 32'd3 + 32'(len));
        end
        a = base + len - 16'd1;
        case (sel)
            2'b00:   m_img = a[13:0];
            2'b01:   m_conv = a;
            default: m_dense = a;
        endcase
        check_addrs("cmd");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin
            img_mem0[i] = 8'($urandom); img_mem1[i] = 8'($urandom);
            img_mem2[i] = 8'($urandom); img_mem3[i] = 8'($urandom);
        end
        for (int i = 0; i < 65536; i++) begin
            conv_mem[i] = 8'($urandom); dense_mem[i] = 8'($urandom);
        end
        reset = 1'b1; start = 1'b0; src_sel = 2'b00; base_addr = 16'h0; length = 16'h0;
        strm.out_ready = 1'b0;
        m_img = 14'h0; m_conv = 16'h0; m_dense = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valid", 32'(strm.out_valid), 32'd0);
        check("rst_last", 32'(strm.out_last), 32'd0);
        check_addrs("rst");
        reset = 1'b0;

        run_cmd(2'b00, 16'd0, 16'd196, 0, 0, -1, 1'b1);
        run_cmd(2'b01, 16'd100, 16'd8, 1, 0, -1, 1'b0);
        run_cmd(2'b10, 16'hFFFE, 16'd4, 0, 0, -1, 1'b1);
        run_imm(2'b01, 16'd300, 16'd0);
        run_imm(2'b11, 16'd777, 16'd5);
        run_cmd(2'b01, 16'd2000, 16'd50, 0, 10, -1, 1'b0);
        run_cmd(2'b00, 16'd40, 16'd100, 0, 0, 10, 1'b0);
        run_cmd(2'b10, 16'd500, 16'd20, 2, 0, -1, 1'b0);
        run_cmd(2'b00, 16'h3FFE, 16'd5, 2, 0, -1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            run_cmd(2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom_range(1, 40)),
                    2, 0, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
